// File: rtl/perm_apply.sv
// rtl/perm_apply.sv - loads and validates a permutation table, then emits each buffered frame in permuted order
module perm_apply #(
  parameter int N    = 100,
  parameter int IDXW = $clog2(N),
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            perm_valid,
  input  logic [IDXW-1:0] perm_idx,
  output logic            perm_ready,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            table_ok,
  output logic            perm_err
);

  typedef enum logic [1:0] {LOAD_PERM, LOAD_DATA, EMIT} state_t;

  // Last legal index, and N widened by one bit so the range check works even when N is a power of two.
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam logic [IDXW:0]   NUM  = (IDXW + 1)'(N);

  state_t          state;
  logic [IDXW-1:0] cnt;
  logic [IDXW-1:0] k;
  logic [N-1:0]    seen;
  logic [IDXW-1:0] ptab [N];
  logic [DW-1:0]   fbuf [N];
  logic            idx_ok;

  assign perm_ready = (state == LOAD_PERM);
  assign in_ready   = (state == LOAD_DATA);

  // An entry is usable only if it is in range and has not already appeared in this table.
  assign idx_ok = ({1'b0, perm_idx} < NUM) && !seen[perm_idx];

  // Table and frame storage carry no reset so they can map onto plain memory.
  always_ff @(posedge clk) begin
    if (perm_ready && perm_valid && idx_ok) ptab[cnt] <= perm_idx;
    if (in_ready && in_valid) fbuf[cnt] <= in_data;
  end

  // Control FSM: table load/validation, frame capture, then permuted emission with a registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_PERM;
      cnt       <= '0;
      k         <= '0;
      seen      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      table_ok  <= 1'b0;
      perm_err  <= 1'b0;
    end else begin
      case (state)
        LOAD_PERM: begin
          if (perm_valid) begin
            if (idx_ok) begin
              seen[perm_idx] <= 1'b1;
              if (cnt == LAST) begin
                state    <= LOAD_DATA;
                table_ok <= 1'b1;
                cnt      <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              // A single bad entry discards the whole partial table.
              perm_err <= 1'b1;
              cnt      <= '0;
              seen     <= '0;
            end
          end
        end
        LOAD_DATA: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              state <= EMIT;
              k     <= '0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= LOAD_DATA;
            cnt       <= '0;
          end else if (!out_valid || out_ready) begin
            out_valid <= 1'b1;
            out_data  <= fbuf[ptab[k]];
            out_last  <= (k == LAST);
            if (k != LAST) k <= k + 1'b1;
          end
        end
        default: state <= LOAD_PERM;
      endcase
    end
  end

endmodule

// File: tb/tb_perm_apply.sv
// tb/tb_perm_apply.sv - directed vector bench for perm_apply at N=4 and N=5
module tb_perm_apply;

  typedef logic [7:0] arr_t [5];
  typedef struct {
    logic sel;
    int   n;
    arr_t perm;
    arr_t data;
    arr_t expo;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sel, pv, iv, ordy;
  logic [2:0] pidx;
  logic [7:0] idata;

  logic       pr4, ir4, ov4, ol4, tok4, perr4;
  logic [7:0] od4;
  logic       pr5, ir5, ov5, ol5, tok5, perr5;
  logic [7:0] od5;

  logic       pr, ir, ov, ol, tok, perr;
  logic [7:0] od;

  assign pr   = sel ? pr5   : pr4;
  assign ir   = sel ? ir5   : ir4;
  assign ov   = sel ? ov5   : ov4;
  assign ol   = sel ? ol5   : ol4;
  assign tok  = sel ? tok5  : tok4;
  assign perr = sel ? perr5 : perr4;
  assign od   = sel ? od5   : od4;

  perm_apply #(.N(4), .IDXW(2), .DW(8)) u4 (
    .clk(clk), .reset(reset),
    .perm_valid(pv & ~sel), .perm_idx(pidx[1:0]), .perm_ready(pr4),
    .in_valid(iv & ~sel), .in_data(idata), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_last(ol4), .out_ready(ordy & ~sel),
    .table_ok(tok4), .perm_err(perr4)
  );

  perm_apply #(.N(5), .IDXW(3), .DW(8)) u5 (
    .clk(clk), .reset(reset),
    .perm_valid(pv & sel), .perm_idx(pidx), .perm_ready(pr5),
    .in_valid(iv & sel), .in_data(idata), .in_ready(ir5),
    .out_valid(ov5), .out_data(od5), .out_last(ol5), .out_ready(ordy & sel),
    .table_ok(tok5), .perm_err(perr5)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pv = 1'b0; iv = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic put_perm(input logic [2:0] v);
    chkb("perm_ready", pr, 1'b1);
    pv = 1'b1; pidx = v;
    @(posedge clk); #1;
    pv = 1'b0;
  endtask

  task automatic put_data(input logic [7:0] v);
    chkb("in_ready", ir, 1'b1);
    iv = 1'b1; idata = v;
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic load_table(input int n, input arr_t p);
    for (int i = 0; i < n; i++) put_perm(p[i][2:0]);
    chkb("table_ok", tok, 1'b1);
    chkb("perm_ready_off", pr, 1'b0);
  endtask

  // Full frame with out_ready held high: exact latency, N consecutive words, in_ready back after last.
  task automatic frame_check(input int n, input arr_t d, input arr_t e);
    ordy = 1'b1;
    for (int i = 0; i < n; i++) put_data(d[i]);
    chkb("valid_gap", ov, 1'b0);
    chkb("in_ready_emit0", ir, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      chkb("out_valid", ov, 1'b1);
      chkd("out_data", od, e[i]);
      chkb("out_last", ol, i == n - 1);
      chkb("in_ready_emit", ir, 1'b0);
      @(posedge clk); #1;
    end
    chkb("valid_drop", ov, 1'b0);
    chkb("in_ready_back", ir, 1'b1);
  endtask

  vec_t vt [5];
  arr_t p2031, p3210, pid, p43210, d_a, d_b, d_1, d_10, d_70, e_a, e_b, e_1, e_10, e_70;
  logic pat [4];
  logic       pre_ov, pre_ol;
  logic [7:0] pre_od;
  int         got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    p2031  = '{8'h2, 8'h0, 8'h3, 8'h1, 8'h0};
    p3210  = '{8'h3, 8'h2, 8'h1, 8'h0, 8'h0};
    pid    = '{8'h0, 8'h1, 8'h2, 8'h3, 8'h0};
    p43210 = '{8'h4, 8'h3, 8'h2, 8'h1, 8'h0};
    d_a    = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    e_a    = '{8'hA2, 8'hA0, 8'hA3, 8'hA1, 8'h00};
    d_b    = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h00};
    e_b    = '{8'hB2, 8'hB0, 8'hB3, 8'hB1, 8'h00};
    d_1    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    e_1    = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    d_10   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00};
    e_10   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00};
    d_70   = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74};
    e_70   = '{8'h74, 8'h73, 8'h72, 8'h71, 8'h70};
    pat    = '{1'b1, 1'b0, 1'b0, 1'b1};

    vt[0].sel = 1'b0; vt[0].n = 4; vt[0].perm = p2031; vt[0].data = d_a; vt[0].expo = e_a;
    vt[1].sel = 1'b0; vt[1].n = 4; vt[1].perm = p3210; vt[1].data = d_1; vt[1].expo = e_1;
    vt[2].sel = 1'b1; vt[2].n = 5; vt[2].perm = p43210;
    vt[2].data = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    vt[2].expo = '{8'h54, 8'h53, 8'h52, 8'h51, 8'h50};
    vt[3].sel = 1'b1; vt[3].n = 5; vt[3].perm = '{8'h1, 8'h3, 8'h0, 8'h4, 8'h2};
    vt[3].data = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64};
    vt[3].expo = '{8'h61, 8'h63, 8'h60, 8'h64, 8'h62};
    vt[4].sel = 1'b0; vt[4].n = 4; vt[4].perm = pid; vt[4].data = d_10; vt[4].expo = e_10;

    sel = 1'b0; ordy = 1'b1; pidx = '0; idata = '0; pv = 1'b0; iv = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Reset state on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chkb("rst_out_valid", ov, 1'b0);
      chkd("rst_out_data", od, 8'h00);
      chkb("rst_out_last", ol, 1'b0);
      chkb("rst_table_ok", tok, 1'b0);
      chkb("rst_perm_err", perr, 1'b0);
      chkb("rst_perm_ready", pr, 1'b1);
      chkb("rst_in_ready", ir, 1'b0);
    end

    // Vector table
    for (int i = 0; i < 5; i++) begin
      sel = vt[i].sel;
      do_reset();
      load_table(vt[i].n, vt[i].perm);
      chkb("vec_perm_err", perr, 1'b0);
      frame_check(vt[i].n, vt[i].data, vt[i].expo);
    end

    // Duplicate entry, then a correct identity table
    sel = 1'b0;
    do_reset();
    put_perm(3'd1);
    put_perm(3'd3);
    chkb("dup_err_early", perr, 1'b0);
    put_perm(3'd1);
    chkb("dup_err", perr, 1'b1);
    chkb("dup_table_ok", tok, 1'b0);
    load_table(4, pid);
    chkb("dup_err_sticky", perr, 1'b1);
    frame_check(4, d_10, e_10);

    // Out-of-range entry on N=5, load restarts at entry 0
    sel = 1'b1;
    do_reset();
    put_perm(3'd2);
    put_perm(3'd6);
    chkb("oor_err", perr, 1'b1);
    chkb("oor_table_ok", tok, 1'b0);
    load_table(5, p43210);
    frame_check(5, d_70, e_70);

    // Backpressure with out_ready pattern 1,0,0,1
    sel = 1'b0;
    do_reset();
    load_table(4, p3210);
    ordy = 1'b0;
    for (int i = 0; i < 4; i++) put_data(d_1[i]);
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      ordy = pat[c % 4];
      pre_ov = ov; pre_od = od; pre_ol = ol;
      @(posedge clk); #1;
      if (pre_ov && ordy) begin
        chkd("bp_data", pre_od, e_1[got]);
        chkb("bp_last", pre_ol, got == 3);
        got++;
      end else if (pre_ov) begin
        chkd("bp_hold", od, pre_od);
      end
      if (got < 4) chkb("bp_in_ready", ir, 1'b0);
    end
    chkd("bp_count", 8'(got), 8'd4);
    chkb("bp_in_ready_after", ir, 1'b1);
    ordy = 1'b1;

    // Table reuse across two back-to-back frames
    do_reset();
    load_table(4, p2031);
    frame_check(4, d_a, e_a);
    frame_check(4, d_b, e_b);

    // Reset in the middle of emission
    do_reset();
    load_table(4, p2031);
    for (int i = 0; i < 4; i++) put_data(d_a[i]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chkd("mid_word2", od, 8'hA3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chkb("mid_out_valid", ov, 1'b0);
    chkb("mid_perm_ready", pr, 1'b1);
    chkb("mid_table_ok", tok, 1'b0);
    chkb("mid_perm_err", perr, 1'b0);
    @(posedge clk); #1;
    chkb("mid_out_valid2", ov, 1'b0);
    load_table(4, p3210);
    frame_check(4, d_1, e_1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
